// File: rtl/acorn128_sequencer.sv
// ACORN-128 control sequencer: walks INIT, AD, message and finalization phases and
// drives the per-step m/ca/cb inputs of the state-update stage. Define ACORN128_FINAL_EN to include FINAL.
module acorn128_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic [15:0]  ad_len,
  input  logic [15:0]  msg_len,
  input  logic         din_valid,
  input  logic         din_bit,
  output logic         din_ready,
  output logic         step_en,
  output logic         mbit_out,
  output logic         ca_out,
  output logic         cb_out,
  output logic         ks_sel,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD_DATA,
    S_AD_PAD,
    S_MSG_DATA,
    S_MSG_PAD
`ifdef ACORN128_FINAL_EN
    , S_FINAL
`endif
  } state_t;

  localparam logic [10:0] INIT_LAST  = 11'd1791;
  localparam logic [10:0] PAD_LAST   = 11'd255;
`ifdef ACORN128_FINAL_EN
  localparam logic [10:0] FINAL_LAST = 11'd767;
`endif

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  // Data phases accept up to 65535 bits, beyond the reach of the 11-bit step counter.
  logic [15:0] bits_q, bits_d;
  logic [15:0] ad_len_q, ad_len_d;
  logic [15:0] msg_len_q, msg_len_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
    end
  end

  // NOTE: every output and next-state variable gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    ad_len_d  = ad_len_q;
    msg_len_d = msg_len_q;
    din_ready = 1'b0;
    step_en   = 1'b0;
    mbit_out  = 1'b0;
    ca_out    = 1'b0;
    cb_out    = 1'b0;
    ks_sel    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ad_len_d  = ad_len;
          msg_len_d = msg_len;
          cnt_d     = '0;
          bits_d    = '0;
          state_d   = S_INIT;
        end
      end

      S_INIT: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
        // Steps 128..255 load the IV; step 256 injects the inverted first key bit.
        if (cnt_q[10:7] == 4'd1)  mbit_out = iv[cnt_q[6:0]];
        else if (cnt_q == 11'd256) mbit_out = ~key[0];
        else                       mbit_out = key[cnt_q[6:0]];
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = (ad_len_q == 16'd0) ? S_AD_PAD : S_AD_DATA;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      S_AD_DATA: begin
        din_ready = 1'b1;
        if (din_valid) begin
          step_en  = 1'b1;
          mbit_out = din_bit;
          ca_out   = 1'b1;
          cb_out   = 1'b1;
          if (bits_q == ad_len_q - 16'd1) begin
            bits_d  = '0;
            cnt_d   = '0;
            state_d = S_AD_PAD;
          end else begin
            bits_d = bits_q + 16'd1;
          end
        end
      end

      S_AD_PAD: begin
        step_en  = 1'b1;
        mbit_out = (cnt_q == 11'd0);
        ca_out   = ~cnt_q[7];
        cb_out   = 1'b1;
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = (msg_len_q == 16'd0) ? S_MSG_PAD : S_MSG_DATA;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      S_MSG_DATA: begin
        din_ready = 1'b1;
        if (din_valid) begin
          step_en  = 1'b1;
          mbit_out = din_bit;
          ca_out   = 1'b1;
          ks_sel   = 1'b1;
          if (bits_q == msg_len_q - 16'd1) begin
            bits_d  = '0;
            cnt_d   = '0;
            state_d = S_MSG_PAD;
          end else begin
            bits_d = bits_q + 16'd1;
          end
        end
      end

      S_MSG_PAD: begin
        step_en  = 1'b1;
        mbit_out = (cnt_q == 11'd0);
        ca_out   = ~cnt_q[7];
        if (cnt_q == PAD_LAST) begin
          cnt_d = '0;
`ifdef ACORN128_FINAL_EN
          state_d = S_FINAL;
`else
          done    = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

`ifdef ACORN128_FINAL_EN
      S_FINAL: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
        if (cnt_q == FINAL_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/acorn128_sequencer.md
ACORN128_SEQUENCER -- requirements
Module: acorn128_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle pulse; begins a run when IDLE.
REQ-004 SHALL have port: key  input  128  key K; key[0] is the first bit injected.
REQ-005 SHALL have port: iv  input  128  IV; iv[0] is the first bit injected.
REQ-006 SHALL have port: ad_len  input  16  associated-data length in bits; sampled at start.
REQ-007 SHALL have port: msg_len  input  16  plaintext length in bits; sampled at start.
REQ-008 SHALL have port: din_valid  input  1  din_bit is valid this cycle.
REQ-009 SHALL have port: din_bit  input  1  AD or plaintext bit, serial.
REQ-010 SHALL have port: din_ready  output  1  high in the AD_DATA and MSG_DATA states only.
REQ-011 SHALL have port: step_en  output  1  state-update stage advances one step this cycle.
REQ-012 SHALL have port: mbit_out  output  1  m_i for the state-update mbit_in input.
REQ-013 SHALL have port: ca_out  output  1  ca_i for the state-update ca_in input.
REQ-014 SHALL have port: cb_out  output  1  cb_i for the state-update cb_in input.
REQ-015 SHALL have port: ks_sel  output  1  high on message-bit steps; keystream is to be XORed with din_bit.
REQ-016 SHALL have port: busy  output  1  high when not in IDLE.
REQ-017 SHALL have port: done  output  1  one-cycle pulse when the final step of a run is issued.

Function
REQ-018 SHALL implement the FSM IDLE -> INIT -> AD_DATA -> AD_PAD -> MSG_DATA -> MSG_PAD -> FINAL -> IDLE, using an 11-bit step counter cleared on every state entry.
REQ-019 SHALL leave IDLE only on start=1; start SHALL be ignored while busy=1.
REQ-020 SHALL issue, in INIT, 1792 steps, one per cycle, with ca=1 and cb=1. m = key[i] for i<128; iv[i-128] for 128<=i<256; key[0]^1 for i=256; key[i mod 128] for 257<=i<1792.
REQ-021 SHALL step in AD_DATA only when din_valid=1 (step_en=din_valid), with m=din_bit, ca=1, cb=1, and exit after ad_len accepted bits. ad_len=0 SHALL skip AD_DATA.
REQ-022 SHALL issue 256 AD_PAD steps, one per cycle: m=1 on step 0 and 0 thereafter; ca=1 for steps 0-127 and 0 for 128-255; cb=1.
REQ-023 SHALL step in MSG_DATA only when din_valid=1, with m=din_bit, ca=1, cb=0, ks_sel=1; it SHALL exit after msg_len bits, and msg_len=0 SHALL skip MSG_DATA.
REQ-024 SHALL issue 256 MSG_PAD steps with the same m and ca pattern as AD_PAD, and cb=0.
REQ-025 SHALL issue 768 FINAL steps with m=0, ca=1, cb=1; done SHALL pulse in the cycle of step 767.
REQ-026 SHALL drive mbit_out, ca_out, cb_out and ks_sel combinationally from state, counter and din_bit, valid in the same cycle as step_en; when step_en=0 they SHALL be 0.
REQ-027 SHALL ignore din_valid outside AD_DATA and MSG_DATA, with no step.
REQ-028 SHALL use registered copies of ad_len and msg_len; input changes during a run SHALL have no effect.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-run, enter IDLE immediately, clear counters and length registers, and drive din_ready, step_en, mbit_out, ca_out, cb_out, ks_sel, busy and done to 0.
REQ-030 SHALL ignore start on the first edge after rst deasserts only if rst is still high at that edge.

Configuration
REQ-031 SHALL, with macro ACORN128_FINAL_EN defined, execute FINAL as in REQ-025.
REQ-032 SHALL, without ACORN128_FINAL_EN, go MSG_PAD -> IDLE, pulse done on MSG_PAD step 255, and omit the FINAL state.

Verification
REQ-033 SHALL cover: key=0x0, iv=0x0, ad_len=0, msg_len=0, start -> exactly 1792+256+256+768=3072 step_en cycles, done pulse at step 3072, then busy=0.
REQ-034 SHALL cover: key[0]=1, INIT -> mbit_out=1 at step 0, mbit_out=0 at step 256 (key[0]^1), mbit_out=1 at step 384.
REQ-035 SHALL cover: ad_len=8 with din_valid toggled every other cycle -> 8 AD steps over 16 cycles, ca=cb=1; AD_PAD step 0 has m=1, step 128 has ca=0 and cb=1.
REQ-036 SHALL cover: msg_len=4, din_bit=1,0,1,1 -> ks_sel=1 on exactly 4 steps, cb=0, mbit_out follows din_bit.
REQ-037 SHALL cover: rst asserted at INIT step 1000 -> all outputs 0 in the same cycle; a new start reruns INIT from step 0.
REQ-038 SHALL cover: build without ACORN128_FINAL_EN and ad_len=msg_len=0 -> done after 2304 steps.
